// File: rtl/display_mux_n.sv
// ============================================================================
// Module   : display_mux_n
// Purpose  : Sequential binary-to-BCD converter feeding a multiplexed,
//            active-low seven-segment display. Optional macro:
//            DISPLAY_LZB_EN (leading-zero blanking).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_mux_n #(
  parameter int WIDTH       = 9,
  parameter int DIGITS      = 4,
  parameter int SIGNED      = 1,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  resultado,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        SSeg,
  output logic [DIGITS-1:0] an
);

  // Decimal digits needed for 2^WIDTH-1 (log10(2) ~ 0.30103).
  localparam int C_NIB_NEED = (WIDTH * 30103) / 100000 + 1;
  localparam int C_NB       = (C_NIB_NEED > DIGITS) ? C_NIB_NEED : DIGITS;
  localparam int C_BW       = 4 * C_NB;
  localparam int C_CW       = $clog2(WIDTH);
  localparam int C_RW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int C_IW       = $clog2(DIGITS);

  localparam logic [C_CW-1:0] C_LAST_STEP = C_CW'(WIDTH - 1);
  localparam logic [C_RW-1:0] C_LAST_REF  = C_RW'(REFRESH_DIV - 1);
  localparam logic [C_IW-1:0] C_LAST_IDX  = C_IW'(DIGITS - 1);
  localparam logic [3:0]      C_DASH      = 4'd10;
  localparam logic [3:0]      C_BLANK     = 4'd11;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_mag;
  logic [C_BW-1:0]  r_bcd;
  logic [C_CW-1:0]  r_step;
  logic             r_neg;
  logic [3:0]       r_dig [DIGITS];
  logic             r_disp_neg;
  logic             r_overflow;
  logic [C_RW-1:0]  r_ref;
  logic [C_IW-1:0]  r_idx;
  logic [DIGITS-1:0] r_an;
  logic [6:0]       r_sseg;

  logic             w_neg_in;
  logic [WIDTH-1:0] w_mag_in;
  logic [C_BW-1:0]  w_adj;
  logic [C_BW-1:0]  w_bcd_next;
  logic             w_ovf;
  logic [3:0]       w_code [DIGITS];

  assign w_neg_in = (SIGNED != 0) && resultado[WIDTH-1];
  assign w_mag_in = w_neg_in ? ({WIDTH{1'b0}} - resultado) : resultado;

  generate
    for (genvar k = 0; k < C_NB; k++) begin : g_dd
      assign w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? (r_bcd[4*k +: 4] + 4'd3)
                                                          : r_bcd[4*k +: 4];
    end
  endgenerate

  assign w_bcd_next = {w_adj[C_BW-2:0], r_mag[WIDTH-1]};

  // The sign takes one position away from the magnitude when negative.
  always_comb begin
    int avail;
    avail = r_neg ? (DIGITS - 1) : DIGITS;
    w_ovf = 1'b0;
    for (int k = 0; k < C_NB; k++) begin
      if ((k >= avail) && (w_bcd_next[4*k +: 4] != 4'd0)) w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mag      <= '0;
      r_bcd      <= '0;
      r_step     <= '0;
      r_neg      <= 1'b0;
      r_disp_neg <= 1'b0;
      r_overflow <= 1'b0;
      for (int p = 0; p < DIGITS; p++) r_dig[p] <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_state <= S_CONV;
            r_neg   <= w_neg_in;
            r_mag   <= w_mag_in;
            r_bcd   <= '0;
            r_step  <= '0;
          end
        end
        S_CONV: begin
          r_bcd  <= w_bcd_next;
          r_mag  <= {r_mag[WIDTH-2:0], 1'b0};
          r_step <= r_step + 1'b1;
          if (r_step == C_LAST_STEP) begin
            r_state    <= S_IDLE;
            r_disp_neg <= r_neg;
            r_overflow <= w_ovf;
            for (int p = 0; p < DIGITS; p++) r_dig[p] <= w_bcd_next[4*p +: 4];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
`ifdef DISPLAY_LZB_EN
    logic lead;
    lead = 1'b1;
`endif
    for (int p = DIGITS - 1; p >= 0; p--) begin
      w_code[p] = r_dig[p];
      if (r_overflow || (r_disp_neg && (p == DIGITS - 1))) begin
        w_code[p] = C_DASH;
      end else begin
`ifdef DISPLAY_LZB_EN
        if (lead && (r_dig[p] == 4'd0) && (p != 0)) w_code[p] = C_BLANK;
        else lead = 1'b0;
`endif
      end
    end
  end

  function automatic logic [6:0] f_decode(input logic [3:0] code);
    case (code)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0010000;
      C_DASH:  f_decode = 7'b0111111;
      default: f_decode = 7'b1111111;
    endcase
  endfunction

  // Scan runs free of the converter; outputs are registered from the current index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ref  <= '0;
      r_idx  <= '0;
      r_an   <= ~DIGITS'(1);
      r_sseg <= 7'b1000000;
    end else begin
      if (r_ref == C_LAST_REF) begin
        r_ref <= '0;
        r_idx <= (r_idx == C_LAST_IDX) ? '0 : (r_idx + 1'b1);
      end else begin
        r_ref <= r_ref + 1'b1;
      end
      r_an   <= ~(DIGITS'(1) << r_idx);
      r_sseg <= f_decode(w_code[r_idx]);
    end
  end

  assign busy     = (r_state == S_CONV);
  assign overflow = r_overflow;
  assign SSeg     = r_sseg;
  assign an       = r_an;

endmodule

`default_nettype wire

// File: doc/display_mux_n.md
# display_mux_n

Parametrised multiplexed seven-segment driver. Converts a signed or unsigned binary value to BCD with a sequential shift-and-add-3 engine, then time-multiplexes the digits across `DIGITS` common-anode positions. Generalises the fixed 9-bit, 4-digit result display to arbitrary width and digit count. Adds:

- a load/busy handshake;
- double-buffered digits, so the display never shows a partial conversion;
- overflow indication.

It sits between the arithmetic datapath and the board's segment/anode pins.

## Interface
- `WIDTH`, default 9: input value width in bits, ≥2.
- `DIGITS`, default 4: number of display positions, 2..8.
- `SIGNED`, default 1: 1 = two's-complement input, 0 = unsigned.
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit, ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `resultado`  in  WIDTH  value to display; sampled only when `load`=1 and idle.
- `load`  in  1  capture strobe.
- `busy`  out  1  high while a conversion is in progress.
- `overflow`  out  1  displayed magnitude does not fit in the available digits.
- `SSeg`  out  7  segments, active-low, `SSeg[0]`=a … `SSeg[6]`=g.
- `an`  out  DIGITS  anodes, active-low one-hot; `an[0]` is the rightmost digit.

## Operation
- **FSM states:** IDLE and CONV.
- **IDLE → CONV** on `load`=1. Captures `resultado`:
  - if `SIGNED`=1 and MSB=1, neg=1 and magnitude = two's-complement negation, held unsigned in WIDTH bits, so -2^(WIDTH-1) is representable;
  - otherwise neg=0 and magnitude = `resultado`.
- **CONV:** one double-dabble step per cycle (add 3 to every BCD nibble ≥5, then shift in the next magnitude bit, MSB first) for exactly WIDTH cycles.
  - The internal BCD register holds enough nibbles for 2^WIDTH-1.
  - On the final step, commit to the display buffer: digit nibbles, the neg flag and `overflow`. Return to IDLE.
- **Overflow:** available magnitude digits = DIGITS-1 if neg, else DIGITS.
  - Overflow = any nonzero BCD nibble at or above that index.
  - On overflow, all positions show dash.
- **Display buffer contents:**
  - the sign position (leftmost, `an[DIGITS-1]`) shows dash when neg;
  - otherwise each position shows its BCD digit.
- **Decode (active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000;
  - dash=0111111, blank=1111111.
- **Scan:**
  - A refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index increments, wrapping DIGITS-1 → 0.
  - `an` = ~(1<<index); `SSeg` = decode of the buffered position at index.
  - Scanning runs continuously and independently of conversion.
- **load while busy:** ignored and not queued.

## Timing
- **Latency:** `load` sampled at edge E0 → `busy`=1 after E0.
  - Steps occur at E1..E_WIDTH.
  - Buffer and `overflow` update at E_WIDTH, and `busy`=0 after E_WIDTH.
  - `busy` is high for exactly WIDTH cycles.
- **Back-to-back:** `load` at E_WIDTH (busy still high at that edge) is ignored; `load` at E_WIDTH+1 is accepted.
- **Output registration:** `SSeg`/`an` are registered. A new buffer value appears the cycle after commit, at the currently scanned position; other positions show it when next scanned.
- **Reset value of every output** (rst_n=0 at any edge, including mid-CONV, which aborts the conversion):
  - state IDLE, `busy`=0, `overflow`=0;
  - buffer = all zero digits, neg=0;
  - refresh counter 0, index 0;
  - `an`=~1 (e.g. 1110), `SSeg`=1000000.

## Configuration
- **`DISPLAY_LZB_EN` defined:** leading-zero blanking.
  - Zeros left of the most significant nonzero digit show blank; position 0 always shows its digit.
  - The sign dash stays at the leftmost position.
  - Examples: +2 → "   2", -2 → "-  2".
- **Undefined:** all zeros are shown ("0002", "-002").
- Overflow dashes are unaffected in both cases.

## Test plan
All scenarios use WIDTH=9, DIGITS=4, SIGNED=1, REFRESH_DIV=4, macro undefined unless stated.

- **Reset:** rst_n=0 for 2 cycles → `an`=1110, `SSeg`=1000000, `busy`=0, `overflow`=0.
- **Positive load:** load 9'd2 → `busy` high 9 cycles. Then positions 0..3 show 0100100, 1000000, 1000000, 1000000, each held 4 cycles with `an` 1110, 1101, 1011, 0111.
- **Negative load:** load 9'h1FE (-2) → "-002", position 3=0111111. Load 9'h100 (-256) → "-256", `overflow`=0.
- **Overflow:** DIGITS=3 instance, load -255 → `overflow`=1, all positions 0111111. Then load 9'd255 → "255", `overflow`=0.
- **Handshake:** `load`=1 with 9'd7 while busy from 9'd128 → display shows "0128". Reset asserted mid-CONV → display "0000", `busy`=0.
- **With `DISPLAY_LZB_EN`:** load 9'd2 → positions 3..1=1111111, position 0=0100100. Load 0 → position 0=1000000, others blank.
